// File: rtl/router_pkg.sv
// Shared header layout, sink FSM encoding and header field helpers
// for the router output-port packet sink.
package router_pkg;

  localparam int LEN_W  = 6;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAY,
    PAR,
    DONE
  } sink_state_t;

  function automatic logic [LEN_W-1:0] hdr_len(
    input logic [DATA_W-1:0] b
  );
    return b[DATA_W-1:ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] hdr_addr(
    input logic [DATA_W-1:0] b
  );
    return b[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/router_sink_ctr.sv
// Mid-packet stall timer and wrapping packet/error counters
// for the router packet sink.
module router_sink_ctr #(
  parameter int STALL_MAX = 31,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_en_i,
  input  logic             stall_clr_i,
  input  logic             pkt_inc_i,
  input  logic             err_inc_i,
  output logic             stall_hit_o,
  output logic [CNT_W-1:0] pkt_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int SW = $clog2(STALL_MAX + 1);
  localparam logic [SW-1:0] HIT = SW'(STALL_MAX - 1);

  logic [SW-1:0]    stall_q, stall_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0] err_q, err_d;

  // Fires on the cycle the stall count would reach STALL_MAX.
  assign stall_hit_o = stall_en_i & (stall_q == HIT);

  always_comb begin
    stall_d = stall_q;
    pkt_d   = pkt_q;
    err_d   = err_q;
    if (stall_clr_i || stall_hit_o) begin
      stall_d = '0;
    end else if (stall_en_i) begin
      stall_d = stall_q + SW'(1);
    end
    if (pkt_inc_i) pkt_d = pkt_q + CNT_W'(1);
    if (err_inc_i) err_d = err_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      pkt_q   <= '0;
      err_q   <= '0;
    end else begin
      stall_q <= stall_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end

  assign pkt_cnt_o = pkt_q;
  assign err_cnt_o = err_q;

endmodule

// File: rtl/router_pkt_sink.sv
// Router output-port reader: drains one packet at a time, checks
// parity and destination, and reports status plus running counts.
module router_pkt_sink
  import router_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PORT_ID   = 2'd0,
  parameter int                STALL_MAX = 31,
  parameter int                CNT_W     = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              vld_out,
  input  logic [DATA_W-1:0] data_out,
  input  logic              sink_ready,
  output logic              read_enb,
  output logic [DATA_W-1:0] byte_out,
  output logic              byte_valid,
  output logic [LEN_W-1:0]  hdr_len,
  output logic              pkt_done,
  output logic              parity_err,
  output logic              addr_err,
  output logic              pkt_abort,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  err_count
);

  sink_state_t state_q, state_d;

  logic              rd_q, rd_d;
  logic              pend_q, pend_d;
  logic [6:0]        issued_q, issued_d;
  logic [LEN_W-1:0]  rcvd_q, rcvd_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              perr_q, perr_d;
  logic              aerr_q, aerr_d;

  logic       accept;
  logic       active;
  logic       act_d;
  logic [6:0] lim;
  logic       stall_hit;
  logic       stall_en;
  logic       err_inc;

  // Registered strobe is gated so no read is ever offered while
  // the consumer is busy.
  assign read_enb   = rd_q & sink_ready;
  assign accept     = read_enb & vld_out;
  assign active     = (state_q == HDR) | (state_q == PAY) |
                      (state_q == PAR);
  assign pkt_done   = (state_q == DONE);
  assign parity_err = pkt_done & perr_q;
  assign addr_err   = pkt_done & aerr_q;
  assign byte_valid = pend_q & (state_q == PAY);
  assign byte_out   = byte_valid ? data_out : '0;
  assign hdr_len    = len_q;
  assign pkt_abort  = stall_hit;

  assign stall_en = active & ~vld_out & ~pend_q & sink_ready;
  assign err_inc  = (pkt_done & (perr_q | aerr_q)) | stall_hit;

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q + 7'(accept);
    rcvd_d   = rcvd_q;
    len_d    = len_q;
    acc_d    = acc_q;
    perr_d   = perr_q;
    aerr_d   = aerr_q;
    pend_d   = accept;
    unique case (state_q)
      IDLE: begin
        if (vld_out) state_d = HDR;
      end
      HDR: begin
        if (pend_q) begin
          len_d   = router_pkg::hdr_len(data_out);
          aerr_d  = router_pkg::hdr_addr(data_out) != PORT_ID;
          acc_d   = data_out;
          perr_d  = 1'b0;
          state_d = (len_d == '0) ? PAR : PAY;
        end
      end
      PAY: begin
        if (pend_q) begin
          acc_d  = acc_q ^ data_out;
          rcvd_d = rcvd_q + LEN_W'(1);
          if (rcvd_d == len_q) state_d = PAR;
        end
      end
      PAR: begin
        if (pend_q) begin
          perr_d  = (data_out != acc_q);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d  = IDLE;
        issued_d = '0;
        rcvd_d   = '0;
        acc_d    = '0;
      end
      default: state_d = IDLE;
    endcase
    if (stall_hit) begin
      state_d  = IDLE;
      issued_d = '0;
      rcvd_d   = '0;
      acc_d    = '0;
    end
  end

  // Until the header lands only two reads may be in flight; DONE
  // pre-issues the next header so back-to-back packets lose 2 cycles.
  always_comb begin
    act_d = (state_d == HDR) | (state_d == PAY) |
            (state_d == PAR);
    lim   = ((state_d == PAY) | (state_d == PAR)) ?
            7'(len_d) + 7'd2 : 7'd2;
    rd_d  = vld_out & ((state_q == DONE) |
                       (act_d & (issued_d < lim)));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      rd_q     <= 1'b0;
      pend_q   <= 1'b0;
      issued_q <= '0;
      rcvd_q   <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      perr_q   <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      pend_q   <= pend_d;
      issued_q <= issued_d;
      rcvd_q   <= rcvd_d;
      len_q    <= len_d;
      acc_q    <= acc_d;
      perr_q   <= perr_d;
      aerr_q   <= aerr_d;
    end
  end

  router_sink_ctr #(
    .STALL_MAX (STALL_MAX),
    .CNT_W     (CNT_W)
  ) u_ctr (
    .clk         (clock),
    .rst_n       (resetn),
    .stall_en_i  (stall_en),
    .stall_clr_i (pend_q | ~active),
    .pkt_inc_i   (pkt_done),
    .err_inc_i   (err_inc),
    .stall_hit_o (stall_hit),
    .pkt_cnt_o   (pkt_count),
    .err_cnt_o   (err_count)
  );

endmodule

// File: tb/tb_router_pkt_sink.sv
// Bench for router_pkt_sink: router FIFO model plus scoreboard of
// expected payload bytes and per-packet status.
module tb_router_pkt_sink;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       vld_out = 1'b0;
  logic [7:0] data_out = 8'h00;
  logic       sink_ready = 1'b0;
  logic       read_enb;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic [5:0] hdr_len;
  logic       pkt_done;
  logic       parity_err;
  logic       addr_err;
  logic       pkt_abort;
  logic [15:0] pkt_count;
  logic [15:0] err_count;

  always #5 clock = ~clock;

  router_pkt_sink #(
    .PORT_ID   (2'd0),
    .STALL_MAX (31),
    .CNT_W     (16)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .vld_out    (vld_out),
    .data_out   (data_out),
    .sink_ready (sink_ready),
    .read_enb   (read_enb),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .hdr_len    (hdr_len),
    .pkt_done   (pkt_done),
    .parity_err (parity_err),
    .addr_err   (addr_err),
    .pkt_abort  (pkt_abort),
    .pkt_count  (pkt_count),
    .err_count  (err_count)
  );

  typedef struct {
    logic       pe;
    logic       ae;
    logic [5:0] len;
  } res_t;

  typedef struct {
    logic [7:0] hdr;
    bit         flip;
    int         srm;
  } vec_t;

  logic [7:0] fifo[$];
  logic [7:0] exp_b[$];
  res_t       exp_r[$];
  int         done_cyc[$];

  int pass_n = 0;
  int fail_n = 0;
  int rd_cnt, bv_cnt, done_cnt, abort_cnt;
  int sr_mode = 0;
  int cyc = 0;
  int exp_pkt = 0;
  int exp_err = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act === exp) pass_n++;
    else begin
      fail_n++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    logic acc;
    res_t r;
    @(negedge clock);
    acc = read_enb && vld_out;
    if (read_enb && !sink_ready) chk("rd_while_busy", 1, 0);
    if (acc) rd_cnt++;
    if (byte_valid) begin
      bv_cnt++;
      if (exp_b.size() == 0) chk("byte_extra", 1, 0);
      else chk("byte_out", byte_out, exp_b.pop_front());
    end
    if (pkt_done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      if (exp_r.size() == 0) chk("done_extra", 1, 0);
      else begin
        r = exp_r.pop_front();
        chk("parity_err", parity_err, r.pe);
        chk("addr_err", addr_err, r.ae);
        chk("hdr_len", hdr_len, r.len);
      end
    end
    if (pkt_abort) abort_cnt++;
    @(posedge clock);
    #1;
    if (acc) data_out = fifo.pop_front();
    vld_out = (fifo.size() != 0);
    cyc++;
    if (sr_mode == 1) sink_ready = ~sink_ready;
    else sink_ready = 1'b1;
  endtask

  task automatic load_pkt(input logic [7:0] hdr, input bit flip,
                          input int nb);
    logic [7:0] p;
    logic [7:0] b;
    res_t r;
    int n;
    n = int'(hdr[7:2]);
    p = hdr;
    fifo.push_back(hdr);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      p = p ^ b;
      if (i < nb) begin
        fifo.push_back(b);
        exp_b.push_back(b);
      end
    end
    if (nb >= n) begin
      fifo.push_back(flip ? (p ^ 8'h01) : p);
      r.pe  = flip;
      r.ae  = (hdr[1:0] != 2'd0);
      r.len = hdr[7:2];
      exp_r.push_back(r);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv[7];
    int   n;
    bit   ae;

    tv[0] = '{8'h20, 1'b0, 0};
    tv[1] = '{8'h20, 1'b1, 0};
    tv[2] = '{8'h0D, 1'b0, 0};
    tv[3] = '{8'h00, 1'b0, 0};
    tv[4] = '{8'h20, 1'b0, 1};
    tv[5] = '{8'hFC, 1'b0, 0};
    tv[6] = '{8'h0F, 1'b1, 0};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_flags", {read_enb, byte_valid, pkt_done, parity_err,
                      addr_err, pkt_abort}, 0);
    chk("rst_data", {byte_out, 2'b00, hdr_len}, 0);
    chk("rst_cnts", {pkt_count, err_count}, 0);
    resetn = 1'b1;
    step();

    for (int t = 0; t < 7; t++) begin
      n  = int'(tv[t].hdr[7:2]);
      ae = (tv[t].hdr[1:0] != 2'd0);
      rd_cnt = 0;
      bv_cnt = 0;
      done_cnt = 0;
      sr_mode = tv[t].srm;
      load_pkt(tv[t].hdr, tv[t].flip, 64);
      vld_out = 1'b1;
      for (int k = 0; k < 400 && done_cnt == 0; k++) step();
      chk("done_seen", done_cnt, 1);
      chk("reads", rd_cnt, n + 2);
      chk("byte_valid_n", bv_cnt, n);
      exp_pkt++;
      if (tv[t].flip || ae) exp_err++;
      chk("pkt_count", pkt_count, exp_pkt);
      chk("err_count", err_count, exp_err);
      sr_mode = 0;
      repeat (3) step();
      chk("done_single", done_cnt, 1);
    end

    // Header plus 4 payload bytes, then the port goes empty.
    bv_cnt = 0;
    done_cnt = 0;
    abort_cnt = 0;
    n = 0;
    load_pkt(8'h20, 1'b0, 4);
    vld_out = 1'b1;
    for (int k = 0; k < 80 && abort_cnt == 0; k++) begin
      step();
      if (!vld_out) n++;
    end
    chk("abort_seen", abort_cnt, 1);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_bytes", bv_cnt, 4);
    chk("abort_stall_len", (n >= 25 && n <= 40), 1);
    exp_err++;
    chk("abort_err_count", err_count, exp_err);
    chk("abort_pkt_count", pkt_count, exp_pkt);
    repeat (5) step();
    chk("abort_single", abort_cnt, 1);

    // Sink must be back in IDLE and accept a fresh packet.
    done_cnt = 0;
    load_pkt(8'h0C, 1'b0, 64);
    vld_out = 1'b1;
    for (int k = 0; k < 100 && done_cnt == 0; k++) step();
    chk("post_abort_done", done_cnt, 1);
    exp_pkt++;
    chk("post_abort_pkt", pkt_count, exp_pkt);

    // Three back-to-back len=5 packets with a fourth queued behind.
    done_cnt = 0;
    done_cyc.delete();
    for (int p = 0; p < 4; p++) load_pkt(8'h14, 1'b0, 64);
    vld_out = 1'b1;
    for (int k = 0; k < 200 && done_cnt < 3; k++) step();
    chk("b2b_done", done_cnt, 3);
    exp_pkt += 3;
    chk("b2b_pkt_count", pkt_count, exp_pkt);
    if (done_cyc.size() == 3) begin
      chk("b2b_gap1", (done_cyc[1] - done_cyc[0]) <= 9, 1);
      chk("b2b_gap2", (done_cyc[2] - done_cyc[1]) <= 9, 1);
    end
    repeat (3) step();
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_flags", {read_enb, byte_valid, pkt_done,
                          parity_err, addr_err, pkt_abort}, 0);
    chk("mid_rst_data", {byte_out, 2'b00, hdr_len}, 0);
    chk("mid_rst_cnts", {pkt_count, err_count}, 0);
    fifo.delete();
    exp_b.delete();
    exp_r.delete();
    vld_out = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    repeat (3) step();
    chk("post_rst_cnts", {pkt_count, err_count}, 0);

    $display("%0d/%0d checks passed", pass_n, pass_n + fail_n);
    $finish;
  end

endmodule

// File: doc/router_pkt_sink.md
Name: router_pkt_sink

Overview:
- Packet reader for one router output port: drains bytes via `vld_out`/`read_enb`/`data_out` and reassembles header, payload and parity.
- Checks parity and destination address, then reports per-packet status and running counters.
- Instantiated once per output port (0..2) beside `router_top`, in both the system and the self-checking benches.
- Packet format: header `{len[5:0], addr[1:0]}`, then `len` payload bytes, then one parity byte (XOR of header and all payload bytes).

Parameters:
- PORT_ID, 2'd0, expected header `addr` field for this port.
- STALL_MAX, 31, max consecutive cycles with `vld_out`=0 mid-packet before abort.
- CNT_W, 16, width of the packet and error counters.

Ports:
- clock, in, 1, system clock, rising edge.
- resetn, in, 1, asynchronous active-low reset.
- vld_out, in, 1, router port FIFO non-empty.
- data_out, in, 8, router port read data; valid the cycle after `read_enb` is sampled high with `vld_out`=1.
- sink_ready, in, 1, downstream consumer can accept a byte.
- read_enb, out, 1, read strobe to router port.
- byte_out, out, 8, captured payload byte.
- byte_valid, out, 1, `byte_out` valid (payload bytes only).
- hdr_len, out, 6, length field of current/last packet.
- pkt_done, out, 1, one-cycle pulse after parity byte is captured.
- parity_err, out, 1, valid with `pkt_done`: computed XOR != received parity.
- addr_err, out, 1, valid with `pkt_done`: header `addr` != PORT_ID.
- pkt_abort, out, 1, one-cycle pulse on stall timeout.
- pkt_count, out, CNT_W, packets completed; wraps.
- err_count, out, CNT_W, packets with `parity_err`|`addr_err`, plus aborts; wraps.

Behaviour:
- Reset (async, `resetn`=0): all outputs 0; state IDLE; all counters, XOR accumulator and stall timer cleared.
- `read_enb` = `vld_out` & `sink_ready` & (state != IDLE/DONE) & (`issued` < `limit`), registered.
  - Before the header is captured, `limit`=2. Safe because every packet is at least 2 bytes.
  - After the header is captured, `limit`=`len`+2.
  - `issued` is a 7-bit count of reads accepted (`read_enb` & `vld_out`).
- `rd_pend` is registered `read_enb` & `vld_out`; each cycle with `rd_pend`=1 captures `data_out`.
- States:
  - IDLE: when `vld_out`=1, go to HDR.
  - HDR: first capture latches `hdr_len` and `addr`, loads `acc`=byte, then goes to PAY; if `len`=0, go straight to PAR.
  - PAY: each capture gives `acc`^=byte, drives `byte_out`/`byte_valid`=1 for that cycle and increments `rcvd`; when `rcvd`==`len`, go to PAR.
  - PAR: capture compares the byte with `acc`, then goes to DONE.
  - DONE: one cycle. `pkt_done`=1 with `parity_err`/`addr_err`; `pkt_count`+1; `err_count`+1 if any error. Then go to IDLE; `issued`/`rcvd` are cleared.
- Latency: header read issued in the cycle after IDLE sees `vld_out`. With `vld_out` and `sink_ready` held high, one byte per cycle. `pkt_done` comes 2 cycles after the parity read strobe.
- Backpressure: `sink_ready`=0 suppresses new reads; a read already pending still completes.
- Stall:
  - Outside IDLE/DONE, `stall` counts cycles with `vld_out`=0 and no read pending; it resets on any capture.
  - At `stall`==STALL_MAX: pulse `pkt_abort`, increment `err_count`, return to IDLE, clear `acc`/`issued`/`rcvd`. `pkt_done` is not pulsed.
- `sink_ready`=0 does not advance `stall`.
- Counters wrap at 2^CNT_W. When `pkt_done` and error coincide, both counters increment in the same cycle.
- Back-to-back packets: IDLE may be re-entered and the next header read issued the cycle after DONE. Throughput loss is at most 2 cycles per packet.
- `resetn` asserted mid-packet: immediate return to reset values. Remaining router bytes are treated as a new packet (router soft reset is out of scope).

Decomposition:
- Shared package router_pkg holds:
  - header field widths: LEN_W=6, ADDR_W=2, DATA_W=8;
  - state encoding `sink_state_t` {IDLE, HDR, PAY, PAR, DONE};
  - `hdr_len()`/`hdr_addr()` extract functions.
- One natural sub-module, router_sink_ctr: the stall timer plus the wrapping pkt/err counters. The FSM and datapath stay in router_pkt_sink.

Test Plan:
- PORT_ID=0, header 8'h20 (`len`=8, `addr`=0), 8 random bytes, correct parity, `sink_ready`=1 → 10 reads, 8 `byte_valid` pulses in order, `pkt_done`=1, both errors 0, `pkt_count`=1.
- Same packet with parity byte bit0 flipped → `pkt_done`=1, `parity_err`=1, `err_count`=1, `pkt_count`=1.
- Header 8'h0D (`len`=3, `addr`=1) on PORT_ID=0 → `addr_err`=1, `parity_err`=0; `len`=0 header 8'h00 + parity 8'h00 → exactly 2 reads, no `byte_valid`.
- `sink_ready` toggled 1/0 every cycle during a `len`=8 packet → `read_enb` never high while `sink_ready`=0; payload identical; `pkt_done` after 10 reads.
- `vld_out` dropped after 4 payload bytes for 31 cycles → `pkt_abort` pulse, `err_count`+1, state IDLE, no `pkt_done`.
- Three back-to-back `len`=5 packets, then `resetn` pulsed low mid-fourth → `pkt_count`=3 before reset, all outputs 0 immediately after `resetn` falls.
